// File: rtl/iir_pkg.sv
// Shared definitions for the floating-point IIR filter chain: FP32 field
// layout and the ADC front-end converter state encoding.
package iir_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    ABS,
    NORM,
    PACK
  } conv_state_e;

endpackage

// File: rtl/adc_fix2fp_if.sv
// Sample/result bundle between the ADC front end and its neighbours.
interface adc_fix2fp_if #(
  parameter int IN_W = 16
);

  logic [IN_W-1:0] i_adc;
  logic            i_adc_valid;
  logic            i_ovr_clr;
  logic [31:0]     o_signal;
  logic            o_valid;
  logic            o_busy;
  logic            o_overrun;

  modport master (
    output i_adc, i_adc_valid, i_ovr_clr,
    input  o_signal, o_valid, o_busy, o_overrun
  );

  modport slave (
    input  i_adc, i_adc_valid, i_ovr_clr,
    output o_signal, o_valid, o_busy, o_overrun
  );

endinterface

// File: rtl/adc_fix2fp.sv
// Signed fixed-point ADC sample to IEEE-754 single converter using a
// bit-serial normaliser; result is held on o_signal between conversions.
module adc_fix2fp
  import iir_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic         clk,
  input  logic         reset_l,
  adc_fix2fp_if.slave  bus
);

  localparam int S_W      = (IN_W > 2) ? $clog2(IN_W) : 1;
  localparam int EXP_BASE = BIAS + IN_W - 1 - FRAC_BITS;

  conv_state_e       state;
  logic [IN_W-1:0]   x;
  logic [IN_W-1:0]   mag;
  logic [IN_W-1:0]   abs_x;
  logic [S_W-1:0]    s;
  logic              sign;
  fp32_t             result;
  fp32_t             packed_c;
  logic [MANT_W-1:0] mant_c;

  // Most negative code negates to 2^(IN_W-1), which still fits unsigned.
  always_comb begin
    abs_x = x[IN_W-1] ? ((~x) + IN_W'(1)) : x;
  end

  always_comb begin
    mant_c = '0;
    mant_c[MANT_W-1 -: IN_W-1] = mag[IN_W-2:0];
    packed_c = '0;
    if (mag != '0) begin
      packed_c.sign = sign;
      packed_c.exp  = EXP_W'(EXP_BASE - int'(s));
      packed_c.mant = mant_c;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state         <= IDLE;
      x             <= '0;
      mag           <= '0;
      s             <= '0;
      sign          <= 1'b0;
      result        <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_busy    <= 1'b0;
      bus.o_overrun <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;

      // A dropped sample outranks a simultaneous clear.
      if (bus.i_adc_valid && bus.o_busy)
        bus.o_overrun <= 1'b1;
      else if (bus.i_ovr_clr)
        bus.o_overrun <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.i_adc_valid) begin
            x          <= bus.i_adc;
            state      <= ABS;
            bus.o_busy <= 1'b1;
          end
        end
        ABS: begin
          sign  <= x[IN_W-1];
          mag   <= abs_x;
          s     <= '0;
          state <= (abs_x == '0) ? PACK : NORM;
        end
        NORM: begin
          if (mag[IN_W-1]) begin
            state <= PACK;
          end else begin
            mag <= mag << 1;
            s   <= s + S_W'(1);
          end
        end
        PACK: begin
          result      <= packed_c;
          bus.o_valid <= 1'b1;
          bus.o_busy  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_signal = result;

endmodule

// File: tb/tb_adc_fix2fp.sv
// Self-checking bench for adc_fix2fp: directed corner samples, random
// samples against a real-arithmetic reference, overrun and reset cases.
module tb_adc_fix2fp;

  localparam int IN_W      = 16;
  localparam int FRAC_BITS = 15;
  localparam int TIMEOUT   = 40;

  logic clk;
  logic reset_l;
  int   n_checks;
  int   n_fails;

  adc_fix2fp_if #(.IN_W(IN_W)) bus ();

  adc_fix2fp #(.IN_W(IN_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value = x / 2^FRAC_BITS as a double, then repacked to single.
  function automatic logic [31:0] ref_fp(input logic [IN_W-1:0] xs);
    real         v;
    logic [63:0] d;
    int          e;
    if (xs == '0) return 32'h0;
    v = real'($signed(xs)) / (2.0 ** FRAC_BITS);
    d = $realtobits(v);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Edges from the capture edge to the PACK edge.
  function automatic int ref_lat(input logic [IN_W-1:0] xs);
    longint m;
    int     s;
    m = $signed(xs);
    if (m < 0) m = -m;
    if (m == 0) return 2;
    s = 0;
    while (m < (longint'(1) << (IN_W - 1))) begin
      m = m * 2;
      s++;
    end
    return s + 3;
  endfunction

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic start(input logic [IN_W-1:0] xs);
    bus.i_adc       = xs;
    bus.i_adc_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_adc_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!bus.o_valid && lat < TIMEOUT) begin
      busy_n += int'(bus.o_busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic convert(input string tag, input logic [IN_W-1:0] xs);
    int lat, busy_n;
    start(xs);
    wait_done(lat, busy_n);
    check({tag, " value"},   bus.o_signal, ref_fp(xs));
    check({tag, " latency"}, 32'(lat),     32'(ref_lat(xs)));
    check({tag, " busy"},    32'(busy_n),  32'(ref_lat(xs)));
    @(negedge clk);
    check({tag, " valid pulse"}, 32'(bus.o_valid), 32'h0);
  endtask

  initial begin
    logic [IN_W-1:0] dir [6];
    logic [IN_W-1:0] r;
    int lat, busy_n, stray;

    n_checks = 0;
    n_fails  = 0;
    bus.i_adc       = '0;
    bus.i_adc_valid = 1'b0;
    bus.i_ovr_clr   = 1'b0;
    reset_l         = 1'b0;
    repeat (2) @(negedge clk);
    check("reset signal",  bus.o_signal,          32'h0);
    check("reset valid",   32'(bus.o_valid),      32'h0);
    check("reset busy",    32'(bus.o_busy),       32'h0);
    check("reset overrun", 32'(bus.o_overrun),    32'h0);
    reset_l = 1'b1;
    @(negedge clk);

    // Directed corners with hand-derived expectations.
    start(16'h4000);
    wait_done(lat, busy_n);
    check("h4000 value", bus.o_signal, 32'h3F00_0000);
    check("h4000 lat",   32'(lat),     32'd4);
    check("h4000 busy",  32'(busy_n),  32'd4);
    @(negedge clk);
    start(16'h8000);
    wait_done(lat, busy_n);
    check("h8000 value", bus.o_signal, 32'hBF80_0000);
    check("h8000 lat",   32'(lat),     32'd3);
    @(negedge clk);
    start(16'h0000);
    wait_done(lat, busy_n);
    check("zero value", bus.o_signal, 32'h0000_0000);
    check("zero lat",   32'(lat),     32'd2);
    @(negedge clk);
    start(16'h0001);
    wait_done(lat, busy_n);
    check("lsb value", bus.o_signal, 32'h3800_0000);
    check("lsb lat",   32'(lat),     32'd18);
    @(negedge clk);

    dir = '{16'h7FFF, 16'hC000, 16'hFFFF, 16'h0100, 16'h8001, 16'h2AAA};
    foreach (dir[i]) convert($sformatf("dir%0d", i), dir[i]);

    for (int i = 0; i < 24; i++) begin
      r = IN_W'($urandom);
      if (i % 4 == 1) r = r >> ($urandom_range(IN_W - 1, 4));
      convert($sformatf("rnd%0d_%h", i, r), r);
    end
    check("no overrun yet", 32'(bus.o_overrun), 32'h0);

    // Second sample arrives while the first is still normalising.
    start(16'h0001);
    @(negedge clk);
    bus.i_adc       = 16'h4000;
    bus.i_adc_valid = 1'b1;
    @(negedge clk);
    bus.i_adc_valid = 1'b0;
    check("overrun set", 32'(bus.o_overrun), 32'h1);
    wait_done(lat, busy_n);
    check("overrun first value", bus.o_signal, 32'h3800_0000);
    check("overrun first lat",   32'(lat) + 32'd2, 32'd18);
    repeat (4) @(negedge clk);
    check("dropped no result", 32'(bus.o_valid),   32'h0);
    check("overrun sticky",    32'(bus.o_overrun), 32'h1);
    bus.i_ovr_clr = 1'b1;
    @(negedge clk);
    bus.i_ovr_clr = 1'b0;
    check("overrun cleared", 32'(bus.o_overrun), 32'h0);

    // Set and clear in the same busy cycle: set wins.
    start(16'h0100);
    bus.i_adc_valid = 1'b1;
    bus.i_ovr_clr   = 1'b1;
    @(negedge clk);
    bus.i_adc_valid = 1'b0;
    bus.i_ovr_clr   = 1'b0;
    check("set beats clear", 32'(bus.o_overrun), 32'h1);
    wait_done(lat, busy_n);
    check("set-clear value", bus.o_signal, ref_fp(16'h0100));
    bus.i_ovr_clr = 1'b1;
    @(negedge clk);
    bus.i_ovr_clr = 1'b0;
    check("overrun cleared 2", 32'(bus.o_overrun), 32'h0);

    // Back-to-back: new sample offered in the o_valid cycle.
    start(16'hC000);
    wait_done(lat, busy_n);
    check("b2b first", bus.o_signal, 32'hBF00_0000);
    start(16'h7FFF);
    wait_done(lat, busy_n);
    check("b2b second",  bus.o_signal, 32'h3F7F_FE00);
    check("b2b lat",     32'(lat),     32'd4);
    check("b2b overrun", 32'(bus.o_overrun), 32'h0);
    @(negedge clk);

    // Reset during NORM aborts the conversion.
    start(16'h0001);
    repeat (5) @(negedge clk);
    reset_l = 1'b0;
    #1;
    check("mid reset signal", bus.o_signal,       32'h0);
    check("mid reset busy",   32'(bus.o_busy),    32'h0);
    check("mid reset valid",  32'(bus.o_valid),   32'h0);
    @(negedge clk);
    reset_l = 1'b1;
    stray = 0;
    repeat (25) begin
      @(negedge clk);
      stray += int'(bus.o_valid);
    end
    check("no valid after abort", 32'(stray), 32'h0);
    convert("post reset h4000", 16'h4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
